fifo_rx_credit: RTL and testbench

Parametrised SpaceWire receive buffer with built-in flow-control credit management. Sits between the receiver character decoder and the host/router read side. Stores N-Chars and issues FCT requests to the transmitter in FCT_CHUNK-sized blocks, only when buffer space is guaranteed. Flags any character that arrives beyond the granted credit.

---
 rtl/fifo_rx_credit.sv | 180 ++++++++++++++++++
 tb/tb_fifo_rx_credit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rx_credit.sv
// fifo_rx_credit: SpaceWire receive buffer with flow-control credit tracking.
// Stores N-Chars from the character decoder and hands them to the consumer.
// It raises fct_req only when room for a further FCT_CHUNK characters is
// guaranteed, and it flags any write that arrives with no credit left.
// Ports:
//   clock, reset (sync, active-low), flush (sync link-reset clear)
//   wr_en/data_in            : write side (decoder)
//   rd_en/data_out/data_valid: read side (registered data, one-cycle valid)
//   f_full/f_empty/almost_full/counter : occupancy status (registered)
//   fct_req/fct_ack/credit   : FCT request handshake and outstanding credit
//   overflow_credit_error    : sticky, a write arrived with credit == 0
module fifo_rx_credit #(
  parameter int unsigned DWIDTH         = 9,
  parameter int unsigned AWIDTH         = 6,
  parameter int unsigned FCT_CHUNK      = 8,
  parameter int unsigned MAX_CREDIT     = 56,
  parameter int unsigned AFULL_LEVEL    = 48,
  parameter int unsigned HANDSHAKE_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              f_full,
  output logic              f_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   counter,
  output logic              fct_req,
  input  logic              fct_ack,
  output logic [6:0]        credit,
  output logic              overflow_credit_error
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     counter_q, counter_d;
  logic [6:0]        credit_q, credit_d;
  logic              fct_req_q, fct_req_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              wr_prev_q, wr_prev_d;
  logic              rd_prev_q, rd_prev_d;

  logic wr_qual, rd_qual, wr_accept, rd_accept, ack_ok, room_ok;

  // Request qualification: per-assertion (edge) or per-cycle (level)
  always_comb begin
    wr_qual = 1'b0;
    rd_qual = 1'b0;
    if (HANDSHAKE_MODE != 0) begin
      wr_qual = wr_en;
      rd_qual = rd_en;
    end else begin
      wr_qual = wr_en & ~wr_prev_q;
      rd_qual = rd_en & ~rd_prev_q;
    end
  end

  // Full/empty judged on the registered pre-cycle flags
  assign wr_accept = wr_qual & ~full_q & ~flush;
  assign rd_accept = rd_qual & ~empty_q & ~flush;
  assign ack_ok    = fct_ack & fct_req_q;

  // Next-state for pointers, occupancy, credit and read data
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    counter_d    = counter_q;
    credit_d     = credit_q;
    err_d        = err_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_prev_d    = wr_en;
    rd_prev_d    = rd_en;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      counter_d = '0;
      credit_d  = '0;
      err_d     = 1'b0;
      wr_prev_d = 1'b0;
      rd_prev_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (rd_accept) begin
        rd_ptr_d     = rd_ptr_q + AWIDTH'(1);
        data_out_d   = mem_q[rd_ptr_q];
        data_valid_d = 1'b1;
      end
      if (wr_accept && !rd_accept) counter_d = counter_q + CW'(1);
      if (rd_accept && !wr_accept) counter_d = counter_q - CW'(1);
      // A no-credit write is stored if there is room but never drives credit below zero
      if (wr_accept && (credit_q != 7'd0)) credit_d = credit_d - 7'd1;
      if (ack_ok) credit_d = credit_d + 7'(FCT_CHUNK);
      if (wr_qual && (credit_q == 7'd0)) err_d = 1'b1;
    end
  end

  // A new FCT is only offered if both the ECSS limit and free buffer space allow it
  assign room_ok = (32'(credit_d) + 32'(FCT_CHUNK) <= 32'(MAX_CREDIT)) &&
                   (32'(counter_d) + 32'(credit_d) + 32'(FCT_CHUNK) <= 32'(DEPTH));

  // Request holds until acknowledged; after an ack it drops for one cycle
  always_comb begin
    fct_req_d = 1'b0;
    if (!flush) begin
      if (fct_req_q) fct_req_d = ~fct_ack;
      else           fct_req_d = room_ok;
    end
  end

  // Status flags derived from the next occupancy so they track counter exactly
  always_comb begin
    full_d  = (counter_d == CW'(DEPTH));
    empty_d = (counter_d == '0);
    afull_d = (counter_d >= CW'(AFULL_LEVEL));
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clock) begin
    if (reset && wr_accept) mem_q[wr_ptr_q] <= data_in;
  end

  // State registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      counter_q    <= '0;
      credit_q     <= '0;
      fct_req_q    <= 1'b0;
      err_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      wr_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      counter_q    <= counter_d;
      credit_q     <= credit_d;
      fct_req_q    <= fct_req_d;
      err_q        <= err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      wr_prev_q    <= wr_prev_d;
      rd_prev_q    <= rd_prev_d;
    end
  end

  assign data_out              = data_out_q;
  assign data_valid            = data_valid_q;
  assign f_full                = full_q;
  assign f_empty               = empty_q;
  assign almost_full           = afull_q;
  assign counter               = counter_q;
  assign fct_req               = fct_req_q;
  assign credit                = credit_q;
  assign overflow_credit_error = err_q;

endmodule

// File: tb/tb_fifo_rx_credit.sv
// Bench for fifo_rx_credit: one edge-mode and one level-mode instance share
// the stimulus; each is checked every cycle against a queue-level model.
module tb_fifo_rx_credit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, flush, wr_en, rd_en, fct_ack;
  logic [8:0] data_in;

  logic [8:0] dout  [2];
  logic [6:0] cnt   [2];
  logic [6:0] cred  [2];
  logic       dv    [2];
  logic       full  [2];
  logic       empty [2];
  logic       afull [2];
  logic       req   [2];
  logic       err   [2];

  fifo_rx_credit #(.HANDSHAKE_MODE(0)) u_edge (
    .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout[0]), .data_valid(dv[0]), .f_full(full[0]),
    .f_empty(empty[0]), .almost_full(afull[0]), .counter(cnt[0]), .fct_req(req[0]),
    .fct_ack(fct_ack), .credit(cred[0]), .overflow_credit_error(err[0]));

  fifo_rx_credit #(.HANDSHAKE_MODE(1)) u_lvl (
    .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout[1]), .data_valid(dv[1]), .f_full(full[1]),
    .f_empty(empty[1]), .almost_full(afull[1]), .counter(cnt[1]), .fct_req(req[1]),
    .fct_ack(fct_ack), .credit(cred[1]), .overflow_credit_error(err[1]));

  // Reference model state: a circular store plus plain counters
  int m_mem [2][64];
  int m_head [2], m_cnt [2], m_credit [2], m_dout [2];
  bit m_err [2], m_req [2], m_dv [2], m_pw [2], m_pr [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input int i, input bit keep_dout);
    m_head[i] = 0; m_cnt[i] = 0; m_credit[i] = 0;
    m_err[i] = 0; m_req[i] = 0; m_dv[i] = 0; m_pw[i] = 0; m_pr[i] = 0;
    if (!keep_dout) m_dout[i] = 0;
  endtask

  task automatic model_cycle(input int i);
    bit wq, rq, wok, rok, aok;
    if (!reset) begin
      model_clear(i, 1'b0);
    end else if (flush) begin
      model_clear(i, 1'b1);
    end else begin
      wq  = (i == 1) ? wr_en : (wr_en && !m_pw[i]);
      rq  = (i == 1) ? rd_en : (rd_en && !m_pr[i]);
      rok = rq && (m_cnt[i] != 0);
      wok = wq && (m_cnt[i] != 64);
      aok = fct_ack && m_req[i];
      if (wq && m_credit[i] == 0) m_err[i] = 1;
      m_dv[i] = rok;
      if (rok) begin
        m_dout[i] = m_mem[i][m_head[i]];
        m_head[i] = (m_head[i] + 1) % 64;
        m_cnt[i]  = m_cnt[i] - 1;
      end
      if (wok) begin
        m_mem[i][(m_head[i] + m_cnt[i]) % 64] = int'(data_in);
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (wok && m_credit[i] > 0) m_credit[i] = m_credit[i] - 1;
      if (aok) m_credit[i] = m_credit[i] + 8;
      if (aok) m_req[i] = 0;
      else if (!m_req[i])
        m_req[i] = (m_credit[i] + 8 <= 56) && (64 - m_cnt[i] - m_credit[i] >= 8);
      m_pw[i] = wr_en;
      m_pr[i] = rd_en;
    end
  endtask

  task automatic compare(input int i);
    string p;
    p = (i == 1) ? "lvl" : "edge";
    check({p, ".counter"},     int'(cnt[i]),   m_cnt[i]);
    check({p, ".f_empty"},     int'(empty[i]), int'(m_cnt[i] == 0));
    check({p, ".f_full"},      int'(full[i]),  int'(m_cnt[i] == 64));
    check({p, ".almost_full"}, int'(afull[i]), int'(m_cnt[i] >= 48));
    check({p, ".credit"},      int'(cred[i]),  m_credit[i]);
    check({p, ".fct_req"},     int'(req[i]),   int'(m_req[i]));
    check({p, ".ovf_err"},     int'(err[i]),   int'(m_err[i]));
    check({p, ".data_valid"},  int'(dv[i]),    int'(m_dv[i]));
    check({p, ".data_out"},    int'(dout[i]),  m_dout[i]);
  endtask

  // One clock: model consumes the inputs the DUT sampled, outputs checked after the edge
  task automatic step();
    @(posedge clock);
    model_cycle(0);
    model_cycle(1);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    fct_ack = 1'b0; data_in = '0;
    repeat (2) step();
    reset = 1'b1;
    step();

    // Collect the full 56 credits
    fct_ack = 1'b1;
    repeat (16) step();
    fct_ack = 1'b0;
    step();

    // Held write: one store in edge mode, five in level mode
    wr_en = 1'b1; data_in = 9'h1A5;
    repeat (5) step();
    wr_en = 1'b0;
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    repeat (2) step();

    // Level fill past credit and past full
    wr_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      data_in = 9'($urandom);
      step();
    end
    rd_en = 1'b1;
    repeat (4) begin
      data_in = 9'($urandom);
      step();
    end
    for (int k = 0; k < 70; k++) begin
      wr_en   = (k % 2) == 0;
      rd_en   = !wr_en;
      data_in = 9'($urandom);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;

    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();

    // Randomized traffic with shifting read/write bias and rare flush/reset
    for (int k = 0; k < 4000; k++) begin
      int wbias;
      wbias   = ((k / 400) % 2 == 0) ? 70 : 35;
      wr_en   = $urandom_range(0, 99) < wbias;
      rd_en   = $urandom_range(0, 99) < (100 - wbias);
      fct_ack = $urandom_range(0, 2) == 0;
      flush   = $urandom_range(0, 299) == 0;
      reset   = !($urandom_range(0, 799) == 0);
      data_in = 9'($urandom);
      step();
    end

    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; fct_ack = 1'b0;
    step();
    reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
